// File: rtl/core_pkg.sv
// Shared decode constants, FSM state type and immediate extractors for the
// control-flow resolution stage.
package core_pkg;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {
    IDLE    = 1'b0,
    RESOLVE = 1'b1
  } br_state_t;

  // I-format immediate, sign-extended.
  function automatic logic [31:0] imm_i(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

  // B-format immediate, sign-extended, bit 0 always zero.
  function automatic logic [31:0] imm_b(input logic [31:0] instr);
    return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

  // J-format immediate, sign-extended, bit 0 always zero.
  function automatic logic [31:0] imm_j(input logic [31:0] instr);
    return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/br_cmp.sv
// Combinational branch comparator: evaluates the condition selected by
// funct3 and flags the two reserved encodings.
module br_cmp
  import core_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] RS1_VAL,
  input  logic [31:0] RS2_VAL,
  output logic        taken,
  output logic        illegal
);

  // Condition select; reserved funct3 values are never taken.
  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (RS1_VAL == RS2_VAL);
      F3_BNE:  taken = (RS1_VAL != RS2_VAL);
      F3_BLT:  taken = ($signed(RS1_VAL) <  $signed(RS2_VAL));
      F3_BGE:  taken = ($signed(RS1_VAL) >= $signed(RS2_VAL));
      F3_BLTU: taken = (RS1_VAL <  RS2_VAL);
      F3_BGEU: taken = (RS1_VAL >= RS2_VAL);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Branch/jump resolution stage feeding the PC: captures a control-flow
// instruction in IDLE and presents a registered decision during RESOLVE.
module branch_resolve
  import core_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [31:0]      INSTR,
  input  logic [31:0]      IP,
  input  logic [31:0]      RS1_VAL,
  input  logic [31:0]      RS2_VAL,
  output logic             b_taken,
  output logic [31:0]      up_amt,
  output logic             illegal_br,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count
);

  br_state_t   state_q, state_d;
  logic [6:0]  op;
  logic        is_cf;
  logic        capture;
  logic        cmp_taken, cmp_illegal;
  logic        cap_taken, cap_illegal;
  logic [31:0] cap_amt;
  logic [31:0] jalr_tgt;

  assign op       = INSTR[6:0];
  assign is_cf    = (op == OP_JAL) || (op == OP_JALR) || (op == OP_BRANCH);
  assign capture  = (state_q == IDLE) && is_cf;
  assign jalr_tgt = (RS1_VAL + imm_i(INSTR)) & ~32'd1;

  br_cmp u_cmp (
    .funct3  (INSTR[14:12]),
    .RS1_VAL (RS1_VAL),
    .RS2_VAL (RS2_VAL),
    .taken   (cmp_taken),
    .illegal (cmp_illegal)
  );

  // Decision and offset for the instruction currently on INSTR.
  always_comb begin
    cap_taken   = 1'b0;
    cap_illegal = 1'b0;
    cap_amt     = '0;
    case (op)
      OP_JAL: begin
        cap_taken = 1'b1;
        cap_amt   = imm_j(INSTR);
      end
      OP_JALR: begin
        cap_taken = 1'b1;
        cap_amt   = jalr_tgt - IP;
      end
      OP_BRANCH: begin
        if (cmp_illegal) begin
          cap_illegal = 1'b1;
        end else begin
          cap_taken = cmp_taken;
          cap_amt   = imm_b(INSTR);
        end
      end
      default: ;
    endcase
  end

  // Next state: one RESOLVE cycle per captured instruction.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (is_cf) state_d = RESOLVE;
      RESOLVE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Output registers hold the capture only for the RESOLVE cycle and are
  // cleared otherwise, so outputs read zero in IDLE straight from flops.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      b_taken    <= 1'b0;
      up_amt     <= '0;
      illegal_br <= 1'b0;
    end else if (capture) begin
      b_taken    <= cap_taken;
      up_amt     <= cap_amt;
      illegal_br <= cap_illegal;
    end else begin
      b_taken    <= 1'b0;
      up_amt     <= '0;
      illegal_br <= 1'b0;
    end
  end

  // Saturating event counters, updated alongside the capture.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      br_count    <= '0;
      taken_count <= '0;
    end else if (capture) begin
      if (br_count != '1) br_count <= br_count + 1'b1;
      if (cap_taken && (taken_count != '1)) taken_count <= taken_count + 1'b1;
    end
  end

endmodule
